// File: rtl/cpu_pkg.sv
// Shared pipeline types: register-file address/data widths and the writeback request
// record used by WB_stage, the long-latency unit and the write-port arbiter.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small buffer for long-latency results waiting for a free register-file write slot.
// Entries can be invalidated in place when a younger pipeline write targets the same register.
module wb_result_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_reg,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  squash,
    input  logic [REG_ADDR_W-1:0] squash_reg,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  head_valid,
    output logic [REG_ADDR_W-1:0] head_reg,
    output logic [DATA_W-1:0]     head_data,
    output logic [CNT_W-1:0]      count,
    output logic [DEPTH-1:0]      rs_match,
    output logic [DEPTH-1:0]      rt_match
);

    wb_req_t          entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Squash runs before pop/push so a same-cycle enqueue to the squashed register survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && entries[i].valid && (entries[i].rd == squash_reg)) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                entries[head_ptr].valid <= 1'b0;
                head_ptr                <= head_ptr + PTR_W'(1);
            end
            if (push) begin
                entries[tail_ptr].valid <= 1'b1;
                entries[tail_ptr].rd    <= push_reg;
                entries[tail_ptr].data  <= push_data;
                tail_ptr                <= tail_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_valid = entries[head_ptr].valid;
    assign head_reg   = entries[head_ptr].rd;
    assign head_data  = entries[head_ptr].data;

    always_comb begin
        rs_match = '0;
        rt_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_match[i] = entries[i].valid && (entries[i].rd == rs);
            rt_match[i] = entries[i].valid && (entries[i].rd == rt);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port: pipeline writeback first, then buffered
// long-latency results, then a direct LLU bypass; also drives hazard and bubble requests.
module rf_write_arbiter
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite_WB,
    input  logic [REG_ADDR_W-1:0] write_reg_WB,
    input  logic [DATA_W-1:0]     write_data_WB,
    input  logic                  llu_valid,
    output logic                  llu_ready,
    input  logic [REG_ADDR_W-1:0] llu_write_reg,
    input  logic [DATA_W-1:0]     llu_write_data,
    input  logic [REG_ADDR_W-1:0] rs_ID,
    input  logic [REG_ADDR_W-1:0] rt_ID,
    output logic                  busy_rs_ID,
    output logic                  busy_rt_ID,
    output logic                  wb_hold,
    output logic                  RegWrite_ID,
    output logic [REG_ADDR_W-1:0] write_reg_ID,
    output logic [DATA_W-1:0]     write_data_ID
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                  pipe_eff;
    logic                  fifo_empty;
    logic                  bypass_ok;
    logic                  grant_head;
    logic                  llu_accept;
    logic                  push;
    logic                  pop;
    logic                  head_valid;
    logic [REG_ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0]     head_data;
    logic [CNT_W-1:0]      count;
    logic [FIFO_DEPTH-1:0] rs_match;
    logic [FIFO_DEPTH-1:0] rt_match;
    logic [STARVE_W-1:0]   starve_cnt;
    wb_req_t               grant;

    assign pipe_eff   = RegWrite_WB && (write_reg_WB != '0);
    assign fifo_empty = (count == '0);
    assign llu_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign llu_accept = llu_valid && llu_ready;
    assign bypass_ok  = fifo_empty && llu_valid && (llu_write_reg != '0);
    assign grant_head = !pipe_eff && head_valid;

    // A squashed (invalid) head is retired silently whenever the pipeline is not using the slot.
    assign pop  = !fifo_empty && (!head_valid || !pipe_eff);
    assign push = llu_accept && (llu_write_reg != '0) && !(!pipe_eff && bypass_ok);

    always_comb begin
        grant = '0;
        if (pipe_eff) begin
            grant.valid = 1'b1;
            grant.rd    = write_reg_WB;
            grant.data  = write_data_WB;
        end else if (head_valid) begin
            grant.valid = 1'b1;
            grant.rd    = head_reg;
            grant.data  = head_data;
        end else if (bypass_ok) begin
            grant.valid = 1'b1;
            grant.rd    = llu_write_reg;
            grant.data  = llu_write_data;
        end
    end

    wb_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_reg   (llu_write_reg),
        .push_data  (llu_write_data),
        .pop        (pop),
        .squash     (pipe_eff),
        .squash_reg (write_reg_WB),
        .rs         (rs_ID),
        .rt         (rt_ID),
        .head_valid (head_valid),
        .head_reg   (head_reg),
        .head_data  (head_data),
        .count      (count),
        .rs_match   (rs_match),
        .rt_match   (rt_match)
    );

    assign busy_rs_ID = (rs_ID != '0) && (|rs_match);
    assign busy_rt_ID = (rt_ID != '0) && (|rt_match);

    always_ff @(posedge clk) begin
        if (reset || fifo_empty || grant_head) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    assign wb_hold = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Register and data keep their last values when no write is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite_ID   <= 1'b0;
            write_reg_ID  <= '0;
            write_data_ID <= '0;
        end else begin
            RegWrite_ID <= grant.valid;
            if (grant.valid) begin
                write_reg_ID  <= grant.rd;
                write_data_ID <= grant.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (depth 2, starvation limit 4) with hand-computed
// expectations checked by immediate assertions.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset;
    logic        RegWrite_WB;
    logic [4:0]  write_reg_WB;
    logic [31:0] write_data_WB;
    logic        llu_valid;
    logic        llu_ready;
    logic [4:0]  llu_write_reg;
    logic [31:0] llu_write_data;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic        busy_rs_ID;
    logic        busy_rt_ID;
    logic        wb_hold;
    logic        RegWrite_ID;
    logic [4:0]  write_reg_ID;
    logic [31:0] write_data_ID;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .RegWrite_WB    (RegWrite_WB),
        .write_reg_WB   (write_reg_WB),
        .write_data_WB  (write_data_WB),
        .llu_valid      (llu_valid),
        .llu_ready      (llu_ready),
        .llu_write_reg  (llu_write_reg),
        .llu_write_data (llu_write_data),
        .rs_ID          (rs_ID),
        .rt_ID          (rt_ID),
        .busy_rs_ID     (busy_rs_ID),
        .busy_rt_ID     (busy_rt_ID),
        .wb_hold        (wb_hold),
        .RegWrite_ID    (RegWrite_ID),
        .write_reg_ID   (write_reg_ID),
        .write_data_ID  (write_data_ID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rw, input logic [4:0] wreg, input logic [31:0] wdata,
                                 input logic lv, input logic [4:0] lreg, input logic [31:0] ldata);
        RegWrite_WB    = rw;
        write_reg_WB   = wreg;
        write_data_WB  = wdata;
        llu_valid      = lv;
        llu_write_reg  = lreg;
        llu_write_data = ldata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        checkOutput({tag, ".we"}, {31'b0, RegWrite_ID}, {31'b0, we});
        checkOutput({tag, ".reg"}, {27'b0, write_reg_ID}, {27'b0, wreg});
        checkOutput({tag, ".data"}, write_data_ID, wdata);
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rs_ID = '0;
        rt_ID = '0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        nextCycle();
        $display("[TB] reset state");
        checkWrite("reset", 0, 0, 0);
        checkOutput("reset.llu_ready", {31'b0, llu_ready}, 1);
        checkOutput("reset.wb_hold", {31'b0, wb_hold}, 0);
        checkOutput("reset.busy_rs", {31'b0, busy_rs_ID}, 0);
        checkOutput("reset.busy_rt", {31'b0, busy_rt_ID}, 0);
        reset = 1'b0;

        // Bypass: idle port, LLU r5=0x1234 with empty FIFO
        nextCycle();
        $display("[TB] bypass");
        applyStimulus(0, 0, 0, 1, 5, 32'h1234);
        rs_ID = 5;
        #1 checkOutput("byp.llu_ready", {31'b0, llu_ready}, 1);
        nextCycle();
        checkWrite("byp.out", 1, 5, 32'h1234);
        checkOutput("byp.not_buffered", {31'b0, busy_rs_ID}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkWrite("byp.hold", 0, 5, 32'h1234);

        // Starvation: pipeline writes r1 every cycle while LLU sends r2, r3, r4
        $display("[TB] starvation");
        applyStimulus(1, 1, 32'hA, 1, 2, 32'h11);
        rs_ID = 2;
        rt_ID = 3;
        #1 checkOutput("stv.n0.ready", {31'b0, llu_ready}, 1);
        nextCycle();
        checkWrite("stv.n1.out", 1, 1, 32'hA);
        applyStimulus(1, 1, 32'hA, 1, 3, 32'h22);
        #1 checkOutput("stv.n1.busy_rs", {31'b0, busy_rs_ID}, 1);
        checkOutput("stv.n1.ready", {31'b0, llu_ready}, 1);
        checkOutput("stv.n1.hold", {31'b0, wb_hold}, 0);
        nextCycle();
        applyStimulus(1, 1, 32'hA, 1, 4, 32'h33);
        #1 checkOutput("stv.n2.ready", {31'b0, llu_ready}, 0);
        checkOutput("stv.n2.busy_rt", {31'b0, busy_rt_ID}, 1);
        nextCycle();
        nextCycle();
        checkOutput("stv.n4.hold", {31'b0, wb_hold}, 0);
        nextCycle();
        checkOutput("stv.n5.hold", {31'b0, wb_hold}, 1);
        checkWrite("stv.n5.out", 1, 1, 32'hA);
        applyStimulus(0, 0, 0, 1, 4, 32'h33);
        #1 checkOutput("stv.n5.ready", {31'b0, llu_ready}, 0);
        nextCycle();
        checkWrite("stv.n6.out", 1, 2, 32'h11);
        checkOutput("stv.n6.hold", {31'b0, wb_hold}, 0);
        checkOutput("stv.n6.busy_rs", {31'b0, busy_rs_ID}, 0);
        checkOutput("stv.n6.ready", {31'b0, llu_ready}, 1);
        nextCycle();
        checkWrite("stv.n7.out", 1, 3, 32'h22);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkWrite("stv.n8.out", 1, 4, 32'h33);
        nextCycle();
        checkOutput("stv.n9.we", {31'b0, RegWrite_ID}, 0);
        checkOutput("stv.n9.ready", {31'b0, llu_ready}, 1);

        // WAW squash of buffered r7
        $display("[TB] squash");
        applyStimulus(1, 1, 32'hA, 1, 7, 32'h5);
        rs_ID = 7;
        nextCycle();
        applyStimulus(1, 7, 32'h9, 0, 0, 0);
        #1 checkOutput("waw.busy_before", {31'b0, busy_rs_ID}, 1);
        nextCycle();
        checkWrite("waw.out", 1, 7, 32'h9);
        checkOutput("waw.busy_after", {31'b0, busy_rs_ID}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("waw.never_written", {31'b0, RegWrite_ID}, 0);
        nextCycle();
        checkOutput("waw.still_idle", {31'b0, RegWrite_ID}, 0);
        checkOutput("waw.ready", {31'b0, llu_ready}, 1);

        // Pipeline write to r0 does not block the FIFO head
        $display("[TB] r0 write");
        applyStimulus(1, 1, 32'hA, 1, 6, 32'h77);
        nextCycle();
        applyStimulus(1, 0, 32'hDEAD, 0, 0, 0);
        nextCycle();
        checkWrite("r0.head", 1, 6, 32'h77);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("r0.idle", {31'b0, RegWrite_ID}, 0);

        // Reset while FIFO is full and output is active
        $display("[TB] mid-drain reset");
        rs_ID = 8;
        rt_ID = 9;
        applyStimulus(1, 1, 32'hA, 1, 8, 32'h88);
        nextCycle();
        applyStimulus(1, 1, 32'hA, 1, 9, 32'h99);
        nextCycle();
        checkOutput("rst.active", {31'b0, RegWrite_ID}, 1);
        applyStimulus(1, 1, 32'hA, 0, 0, 0);
        reset = 1'b1;
        #1 checkOutput("rst.full", {31'b0, llu_ready}, 0);
        checkOutput("rst.busy_rs_pre", {31'b0, busy_rs_ID}, 1);
        nextCycle();
        checkWrite("rst.out", 0, 0, 0);
        checkOutput("rst.ready", {31'b0, llu_ready}, 1);
        checkOutput("rst.hold", {31'b0, wb_hold}, 0);
        checkOutput("rst.busy_rs", {31'b0, busy_rs_ID}, 0);
        checkOutput("rst.busy_rt", {31'b0, busy_rt_ID}, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("rst.no_old1", {31'b0, RegWrite_ID}, 0);
        nextCycle();
        checkOutput("rst.no_old2", {31'b0, RegWrite_ID}, 0);

        // Head grant with full FIFO: accept waits one cycle, order preserved
        $display("[TB] full FIFO ordering");
        rs_ID = 0;
        rt_ID = 0;
        applyStimulus(1, 1, 32'hA, 1, 10, 32'hA0);
        nextCycle();
        applyStimulus(1, 1, 32'hA, 1, 11, 32'hB0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 12, 32'hC0);
        #1 checkOutput("ord.full_ready", {31'b0, llu_ready}, 0);
        checkOutput("ord.r0_not_busy", {31'b0, busy_rs_ID}, 0);
        nextCycle();
        checkWrite("ord.first", 1, 10, 32'hA0);
        checkOutput("ord.ready_again", {31'b0, llu_ready}, 1);
        nextCycle();
        checkWrite("ord.second", 1, 11, 32'hB0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkWrite("ord.third", 1, 12, 32'hC0);
        nextCycle();
        checkOutput("ord.drained", {31'b0, RegWrite_ID}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the in-order pipeline writeback path and a long-latency unit (multiplier/divider) that retires out of band. Pipeline writes always win. Long-latency results wait in a small FIFO and drain into idle write slots. A starvation counter requests a pipeline bubble, and a pending-register scoreboard lets ID detect hazards on buffered results. The block sits between WB_stage/LLU outputs and the register file in ID.

## Interface
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may be denied before a bubble is requested
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- RegWrite_WB  in  1  pipeline writeback valid
- write_reg_WB  in  5  pipeline destination register
- write_data_WB  in  32  pipeline write data
- llu_valid  in  1  long-latency result valid
- llu_ready  out  1  arbiter can accept a long-latency result
- llu_write_reg  in  5  long-latency destination register
- llu_write_data  in  32  long-latency result
- rs_ID, rt_ID  in  5 each  ID source registers for hazard lookup
- busy_rs_ID, busy_rt_ID  out  1 each  source matches a valid FIFO entry
- wb_hold  out  1  request to insert a bubble into the pipeline writeback slot
- RegWrite_ID  out  1  registered write enable to register file
- write_reg_ID  out  5  registered destination
- write_data_ID  out  32  registered write data

## Operation
- An effective pipeline write is RegWrite_WB=1 with write_reg_WB≠0. Writes to r0 are dropped from every source: they never grant, never enqueue, never output.
- Grant priority each cycle:
  1. Effective pipeline write.
  2. FIFO head.
  3. Bypass of the current LLU input when the FIFO is empty, llu_valid=1 and llu_write_reg≠0.
- llu_ready = (count < FIFO_DEPTH). It depends only on registered state.
- An LLU accept is llu_valid && llu_ready.
  - A bypass-granted accept does not enter the FIFO.
  - Any other accept enqueues at the tail.
  - An LLU result to r0 is accepted and discarded.
- Simultaneous enqueue and dequeue are allowed; count is unchanged.
- WAW squash: an effective pipeline write whose register matches valid FIFO entries clears those entries' valid bits. The pipeline instruction is younger. A squashed head is popped without granting.
  - A same-cycle LLU accept to the same register still enqueues, because it is younger than the pipeline write.
- Scoreboard: busy_rs_ID / busy_rt_ID are combinational compares against valid FIFO entries. A source of 0 never reports busy.
- Starvation counter starve_cnt:
  - Clears on reset, when the FIFO is empty, or when the head is granted.
  - Otherwise increments and saturates at STARVE_LIMIT.
  - wb_hold = (starve_cnt == STARVE_LIMIT).
  - wb_hold deasserts the cycle after the head is granted.
- Output register: on each edge it loads the grant. RegWrite_ID=1 with the granted register and data, or RegWrite_ID=0 when nothing is granted. Register and data then hold their previous values.

## Timing
- Grant decided in cycle N; RegWrite_ID/write_reg_ID/write_data_ID valid in cycle N+1, so latency is 1 from every source.
- Bypass latency: LLU result presented in N reaches the RF port in N+1.
- Enqueue in N makes the entry visible to the scoreboard and to arbitration in N+1.
- Reset (any cycle, including mid-drain):
  - count=0, all valid bits 0, starve_cnt=0.
  - RegWrite_ID=0, write_reg_ID=0, write_data_ID=0.
  - llu_ready=1, wb_hold=0, busy_* =0 from the following cycle.
  - Buffered results are discarded.
- FIFO full with llu_valid=1: llu_ready=0 and nothing is accepted. The LLU must hold its result.
- Pointers wrap modulo FIFO_DEPTH. count has width clog2(FIFO_DEPTH)+1.

## Structure
- Shared package (cpu_pkg): REG_ADDR_W=5, DATA_W=32, and a wb_req_t struct {valid, reg, data}. WB_stage and the LLU use it too.
- One sub-module: wb_result_fifo (tail enqueue, head pop, per-entry valid clear by register match, per-entry register compare vector for the scoreboard).
- The arbiter, starvation counter and output register live in the top module.

## Test plan
- Idle port, LLU presents r5=0x1234 with FIFO empty → llu_ready=1; next cycle RegWrite_ID=1, write_reg_ID=5, write_data_ID=0x1234; count stays 0.
- Pipeline writes r1=0xA every cycle while LLU sends r2=0x11, r3=0x22, r4=0x33:
  - first two enqueue and llu_ready drops;
  - busy_rs_ID=1 for rs_ID=2;
  - wb_hold rises after 4 denied cycles;
  - dropping RegWrite_WB for one cycle outputs r2=0x11, with wb_hold low the cycle after.
- FIFO holds r7=0x5 and the pipeline writes r7=0x9 → next cycle output is r7=0x9; the r7 entry is squashed and never written; busy for r7 clears.
- Pipeline write to r0 with FIFO head r6=0x77 → head granted; next cycle RegWrite_ID=1, write_reg_ID=6.
- Reset asserted while FIFO is full and output is active → next cycle RegWrite_ID=0, llu_ready=1, wb_hold=0, busy_*=0; no old entry is ever written afterwards.
- Simultaneous head grant and LLU accept with a full FIFO of depth 2 → llu_ready=0, no accept; next cycle llu_ready=1 and the accept succeeds; output order matches arrival order.
